immediate_decoder: RTL and testbench
====================================

IMMEDIATE_DECODER -- requirements
Module: immediate_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (async active-low reset).
REQ-002 The block SHALL have port in_valid, input, 1 bit: instruction word is valid this cycle.
REQ-003 The block SHALL have port instruction, input, 32 bits: RV64 instruction word.
REQ-004 The block SHALL have port out_valid, output, 1 bit: registered copy of in_valid.
REQ-005 The block SHALL have port immediate, output, 64 bits: decoded, sign-extended immediate.
REQ-006 The block SHALL have port imm_fmt, output, 3 bits: 0=none, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-007 The block SHALL have port fmt_illegal, output, 1 bit: opcode is not in the supported set.

Function
REQ-008 Format SHALL be selected by instruction[6:0]; instruction[1:0] != 2'b11 SHALL be treated as unsupported.
REQ-009 I-type opcodes 0000011, 0010011, 0011011, 1100111, 1110011 SHALL give immediate = sext(instruction[31:20]).
REQ-010 Shift-immediate encodings (OP-IMM funct3 001/101) SHALL get no special handling; they SHALL be decoded as plain I-type.
REQ-011 S-type opcode 0100011 SHALL give immediate = sext({instruction[31:25], instruction[11:7]}).
REQ-012 B-type opcode 1100011 SHALL give immediate = sext({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}).
REQ-013 U-type opcodes 0110111 and 0010111 SHALL give immediate = sext({instruction[31:12], 12'b0}).
REQ-014 J-type opcode 1101111 SHALL give immediate = sext({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}).
REQ-015 Sign extension SHALL replicate instruction[31] into every bit above the field's MSB, up to bit 63.
REQ-016 Any other opcode SHALL give immediate = 0, imm_fmt = 0 and fmt_illegal = 1.
REQ-017 Latency SHALL be exactly 1 cycle: values sampled on rising edge N SHALL appear on the outputs after edge N.
REQ-018 When in_valid=1 at an edge, immediate, imm_fmt and fmt_illegal SHALL update, and out_valid SHALL be 1.
REQ-019 When in_valid=0 at an edge, immediate, imm_fmt and fmt_illegal SHALL hold their previous values, and out_valid SHALL be 0.
REQ-020 Back-to-back valid inputs SHALL be accepted every cycle, with no stall or backpressure.
REQ-021 Outputs SHALL depend only on the registered state; there SHALL be no combinational path from the inputs to the outputs.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for a clock edge, force immediate=0, imm_fmt=0, fmt_illegal=0 and out_valid=0.
REQ-023 While rst_n=0, the block SHALL ignore in_valid and instruction.
REQ-024 After rst_n is released, the first rising edge with in_valid=1 SHALL decode normally.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result.

Verification
REQ-026 beq x1,x2,-20 (B-type, bit31=1, [30:25]=111111, [11:8]=0110, bit7=1) -> immediate=-20 (0xFFFFFFFFFFFFFFEC), imm_fmt=3.
REQ-027 addi x5,x4,50 -> immediate=50, imm_fmt=1; store with imm[11:5]=0 and imm[4:0]=10010 -> immediate=18, imm_fmt=2.
REQ-028 0x3A4000EF (JAL) -> immediate=932, imm_fmt=5; 0x00800067 (JALR) -> immediate=8, imm_fmt=1.
REQ-029 0x00001297 (AUIPC x5) -> immediate=4096, imm_fmt=4; 0x80000037 (LUI) -> immediate=0xFFFFFFFF80000000.
REQ-030 0x00000033 (OP, R-type) -> immediate=0, imm_fmt=0, fmt_illegal=1; a following cycle with in_valid=0 -> outputs hold, out_valid=0.
REQ-031 Assert rst_n=0 between clock edges while a valid result is held -> all outputs 0 immediately; release, then drive addi 50 -> immediate=50 one cycle later.

Source files
------------

// File: rtl/immediate_decoder.sv
// rtl/immediate_decoder.sv - RV64 immediate extraction and format classification, one registered stage
module immediate_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [63:0] immediate,
    output logic [2:0]  imm_fmt,
    output logic        fmt_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic [63:0] imm_d;
    logic [2:0]  fmt_d;
    logic        illegal_d;
    logic        sign;

    assign sign = instruction[31];

    // Every listed opcode ends in 2'b11, so compressed encodings fall to the default arm.
    always_comb begin
        imm_d     = 64'd0;
        fmt_d     = FMT_NONE;
        illegal_d = 1'b0;
        case (instruction[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                imm_d = {{52{sign}}, instruction[31:20]};
                fmt_d = FMT_I;
            end
            7'b0100011: begin
                imm_d = {{52{sign}}, instruction[31:25], instruction[11:7]};
                fmt_d = FMT_S;
            end
            7'b1100011: begin
                imm_d = {{51{sign}}, sign, instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
                fmt_d = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                imm_d = {{32{sign}}, instruction[31:12], 12'd0};
                fmt_d = FMT_U;
            end
            7'b1101111: begin
                imm_d = {{43{sign}}, sign, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
                fmt_d = FMT_J;
            end
            default: begin
                imm_d     = 64'd0;
                fmt_d     = FMT_NONE;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Decoded fields only move on a valid beat; idle cycles keep the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            immediate   <= 64'd0;
            imm_fmt     <= FMT_NONE;
            fmt_illegal <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                immediate   <= imm_d;
                imm_fmt     <= fmt_d;
                fmt_illegal <= illegal_d;
            end
        end
    end

endmodule

// File: tb/tb_immediate_decoder.sv
// tb/tb_immediate_decoder.sv - directed-vector self-checking bench for immediate_decoder
module tb_immediate_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [63:0] immediate;
    logic [2:0]  imm_fmt;
    logic        fmt_illegal;

    int tests_run;
    int tests_failed;

    immediate_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .immediate   (immediate),
        .imm_fmt     (imm_fmt),
        .fmt_illegal (fmt_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_valid,
                                 input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                                 input logic exp_ill);
        check({tag, ".out_valid"},   {63'd0, out_valid},   {63'd0, exp_valid});
        check({tag, ".immediate"},   immediate,            exp_imm);
        check({tag, ".imm_fmt"},     {61'd0, imm_fmt},     {61'd0, exp_fmt});
        check({tag, ".fmt_illegal"}, {63'd0, fmt_illegal}, {63'd0, exp_ill});
    endtask

    // Drive one beat between edges, then sample just after the capturing edge.
    task automatic beat(input string tag, input logic v, input logic [31:0] instr,
                        input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                        input logic exp_ill);
        @(negedge clk);
        in_valid    = v;
        instruction = instr;
        @(posedge clk);
        #1;
        check_outputs(tag, v, exp_imm, exp_fmt, exp_ill);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b1;
        instruction  = 32'h03220293;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset_ignores_inputs", 1'b0, 64'd0, 3'd0, 1'b0);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        beat("beq_m20",    1'b1, 32'hFE2086E3, 64'hFFFFFFFFFFFFFFEC, 3'd3, 1'b0);
        beat("addi_50",    1'b1, 32'h03220293, 64'd50,               3'd1, 1'b0);
        beat("sw_18",      1'b1, 32'h0020A923, 64'd18,               3'd2, 1'b0);
        beat("sw_m1",      1'b1, 32'hFE000FA3, 64'hFFFFFFFFFFFFFFFF, 3'd2, 1'b0);
        beat("jal_932",    1'b1, 32'h3A4000EF, 64'd932,              3'd5, 1'b0);
        beat("jalr_8",     1'b1, 32'h00800067, 64'd8,                3'd1, 1'b0);
        beat("auipc_4096", 1'b1, 32'h00001297, 64'd4096,             3'd4, 1'b0);
        beat("lui_neg",    1'b1, 32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        beat("addi_m1",    1'b1, 32'hFFF00013, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        beat("slli_3",     1'b1, 32'h00309293, 64'd3,                3'd1, 1'b0);
        beat("srai_3",     1'b1, 32'h4030D293, 64'd1027,             3'd1, 1'b0);
        beat("csr_m1",     1'b1, 32'hFFF01073, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        beat("compressed", 1'b1, 32'hFFFFFFF0, 64'd0,                3'd0, 1'b1);
        beat("lui_again",  1'b1, 32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        beat("r_type",     1'b1, 32'h00000033, 64'd0,                3'd0, 1'b1);
        beat("hold_illeg", 1'b0, 32'h3A4000EF, 64'd0,                3'd0, 1'b1);
        beat("addi_50_b",  1'b1, 32'h03220293, 64'd50,               3'd1, 1'b0);
        beat("hold_addi",  1'b0, 32'hFE2086E3, 64'd50,               3'd1, 1'b0);

        // Async reset between edges while a valid result is held.
        @(negedge clk);
        in_valid    = 1'b1;
        instruction = 32'hFE2086E3;
        @(posedge clk);
        #1;
        check_outputs("pre_reset", 1'b1, 64'hFFFFFFFFFFFFFFEC, 3'd3, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 64'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        beat("post_reset_addi", 1'b1, 32'h03220293, 64'd50, 3'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
